// File: rtl/vga_pkg.sv
`timescale 1ns/1ps
// Shared VGA constants, the text-cell word layout and the cell address helper.
package vga_pkg;

    localparam int H_VIS    = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_TOT    = 800;
    localparam int V_VIS    = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_TOT    = 525;
    localparam int TXT_COLS = 80;
    localparam int TXT_ROWS = 30;

    // Character word as stored in text VRAM and consumed by color_mapper.
    typedef struct packed {
        logic       invert;
        logic [6:0] glyph;
        logic [2:0] fg_idx;
        logic       fg_half;
        logic [2:0] bg_idx;
        logic       bg_half;
    } char_word_t;

    // Word address of the 8x16 cell covering pixel (x,y): row*80 + col, built
    // from two shifts so no multiplier is needed.
    function automatic logic [11:0] cell_addr(input logic [9:0] x, input logic [9:0] y);
        logic [11:0] row;
        logic [11:0] col;
        row = {2'b00, y} >> 4;
        col = {2'b00, x} >> 3;
        return (row << 6) + (row << 4) + col;
    endfunction

endpackage

// File: rtl/vga_timing_cnt.sv
`timescale 1ns/1ps
// Raster position counters plus visible/sync/start-of-vblank decode.
module vga_timing_cnt #(
    parameter int H_VIS  = vga_pkg::H_VIS,
    parameter int H_FP   = vga_pkg::H_FP,
    parameter int H_SYNC = vga_pkg::H_SYNC,
    parameter int H_TOT  = vga_pkg::H_TOT,
    parameter int V_VIS  = vga_pkg::V_VIS,
    parameter int V_FP   = vga_pkg::V_FP,
    parameter int V_SYNC = vga_pkg::V_SYNC,
    parameter int V_TOT  = vga_pkg::V_TOT
) (
    input  logic       pixel_clk,
    input  logic       reset_n,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic [9:0] hc_nxt,
    output logic [9:0] vc_nxt,
    output logic       vis,
    output logic       vis_nxt,
    output logic       hs_n,
    output logic       vs_n,
    output logic       tick
);
    import vga_pkg::*;

    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

    // Next raster position: hc wraps at end of line and steps vc, vc wraps at end of frame.
    always_comb begin
        hc_nxt = hc + 10'd1;
        vc_nxt = vc;
        if (hc == H_LAST) begin
            hc_nxt = 10'd0;
            vc_nxt = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
        end
    end

    // Position registers, cleared immediately by reset.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc <= 10'd0;
            vc <= 10'd0;
        end else begin
            hc <= hc_nxt;
            vc <= vc_nxt;
        end
    end

    assign vis     = (hc < H_VIS_W) && (vc < V_VIS_W);
    assign vis_nxt = (hc_nxt < H_VIS_W) && (vc_nxt < V_VIS_W);
    assign hs_n    = !((hc >= HS_FIRST) && (hc <= HS_LAST));
    assign vs_n    = !((vc >= VS_FIRST) && (vc <= VS_LAST));
    assign tick    = (hc == 10'd0) && (vc == V_VIS_W);

endmodule

// File: rtl/vga_text_fetch.sv
`timescale 1ns/1ps
// VGA timing source with a two-stage text prefetch so that char/font_data
// line up with DrawX/DrawY in the same output cycle.
module vga_text_fetch #(
    parameter int H_VIS  = vga_pkg::H_VIS,
    parameter int H_FP   = vga_pkg::H_FP,
    parameter int H_SYNC = vga_pkg::H_SYNC,
    parameter int H_TOT  = vga_pkg::H_TOT,
    parameter int V_VIS  = vga_pkg::V_VIS,
    parameter int V_FP   = vga_pkg::V_FP,
    parameter int V_SYNC = vga_pkg::V_SYNC,
    parameter int V_TOT  = vga_pkg::V_TOT
) (
    input  logic        pixel_clk,
    input  logic        reset_n,
    output logic [11:0] vram_addr,
    input  logic [15:0] vram_q,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_q,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic [15:0] char,
    output logic [7:0]  font_data,
    output logic        frame_tick
);
    import vga_pkg::*;

    logic [9:0] hc, vc, hc_nxt, vc_nxt;
    logic       vis, vis_nxt, hs_n, vs_n, tick;

    logic [9:0] hc1, vc1;
    logic       vis1, hs1, vs1, tick1;
    char_word_t word1;
    char_word_t char_q;

    vga_timing_cnt #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_TOT(H_TOT),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_TOT(V_TOT)
    ) u_timing (
        .pixel_clk (pixel_clk),
        .reset_n   (reset_n),
        .hc        (hc),
        .vc        (vc),
        .hc_nxt    (hc_nxt),
        .vc_nxt    (vc_nxt),
        .vis       (vis),
        .vis_nxt   (vis_nxt),
        .hs_n      (hs_n),
        .vs_n      (vs_n),
        .tick      (tick)
    );

    // VRAM address is loaded from the next position so it is in step with hc/vc;
    // outside the visible area it keeps the last cell address.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            vram_addr <= 12'd0;
        end else if (vis_nxt) begin
            vram_addr <= cell_addr(hc_nxt, vc_nxt);
        end
    end

    // Stage 1: carry position and timing alongside the VRAM read in flight.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc1   <= 10'd0;
            vc1   <= 10'd0;
            vis1  <= 1'b0;
            hs1   <= 1'b1;
            vs1   <= 1'b1;
            tick1 <= 1'b0;
        end else begin
            hc1   <= hc;
            vc1   <= vc;
            vis1  <= vis;
            hs1   <= hs_n;
            vs1   <= vs_n;
            tick1 <= tick;
        end
    end

    // The VRAM word for the stage-1 pixel is already on vram_q, so the font row
    // lookup is issued straight from it and returns in the output cycle.
    assign word1     = vram_q;
    assign font_addr = vis1 ? {word1.glyph, vc1[3:0]} : 11'd0;

    // Stage 2: registered outputs; blanked pixels force the character word to zero.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX      <= 10'd0;
            DrawY      <= 10'd0;
            blank      <= 1'b0;
            hs         <= 1'b1;
            vs         <= 1'b1;
            char_q     <= '0;
            frame_tick <= 1'b0;
        end else begin
            DrawX      <= hc1;
            DrawY      <= vc1;
            blank      <= vis1;
            hs         <= hs1;
            vs         <= vs1;
            char_q     <= vis1 ? word1 : '0;
            frame_tick <= tick1;
        end
    end

    assign char      = char_q;
    assign font_data = blank ? font_q : 8'd0;

endmodule

// File: tb/tb_vga_text_fetch.sv
`timescale 1ns/1ps
// Self-checking bench for vga_text_fetch with VRAM and font ROM models.
module tb_vga_text_fetch;

    // Small raster so several whole frames fit in a short run.
    localparam int TH_VIS  = 64;
    localparam int TH_FP   = 8;
    localparam int TH_SYNC = 16;
    localparam int TH_TOT  = 96;
    localparam int TV_VIS  = 48;
    localparam int TV_FP   = 4;
    localparam int TV_SYNC = 2;
    localparam int TV_TOT  = 58;
    localparam int FRAME   = TH_TOT * TV_TOT;

    logic        pixel_clk = 1'b0;
    logic        reset_n   = 1'b0;
    logic [11:0] vram_addr;
    logic [15:0] vram_q    = 16'h0;
    logic [10:0] font_addr;
    logic [7:0]  font_q    = 8'h0;
    logic [9:0]  DrawX, DrawY;
    logic        blank, hs, vs, frame_tick;
    logic [15:0] char_w;
    logic [7:0]  font_data;

    logic [15:0] vram [4096];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          x;
        int          y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        tick;
        logic [15:0] ch;
        logic [7:0]  fd;
    } exp_t;

    vga_text_fetch #(
        .H_VIS(TH_VIS), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_TOT(TH_TOT),
        .V_VIS(TV_VIS), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_TOT(TV_TOT)
    ) dut (
        .pixel_clk  (pixel_clk),
        .reset_n    (reset_n),
        .vram_addr  (vram_addr),
        .vram_q     (vram_q),
        .font_addr  (font_addr),
        .font_q     (font_q),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .hs         (hs),
        .vs         (vs),
        .char       (char_w),
        .font_data  (font_data),
        .frame_tick (frame_tick)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Synchronous VRAM and a font ROM whose data is its own low address byte.
    always @(posedge pixel_clk) begin
        vram_q <= vram[vram_addr];
        font_q <= font_addr[7:0];
    end

    // Clock edges since the last reset release.
    always @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Expected outputs k edges after release: pixel k-2 of the frame, reset values before.
    function automatic exp_t model(input int k);
        exp_t e;
        int   p;
        e = '{x:0, y:0, blank:1'b0, hs:1'b1, vs:1'b1, tick:1'b0, ch:16'h0, fd:8'h0};
        if (k >= 2) begin
            p       = (k - 2) % FRAME;
            e.x     = p % TH_TOT;
            e.y     = p / TH_TOT;
            e.blank = (e.x < TH_VIS) && (e.y < TV_VIS);
            e.hs    = !((e.x >= TH_VIS + TH_FP) && (e.x < TH_VIS + TH_FP + TH_SYNC));
            e.vs    = !((e.y >= TV_VIS + TV_FP) && (e.y < TV_VIS + TV_FP + TV_SYNC));
            e.tick  = (e.x == 0) && (e.y == TV_VIS);
            if (e.blank) begin
                e.ch = vram[(e.y / 16) * 80 + e.x / 8];
                e.fd = {e.ch[11:8], 4'(e.y % 16)};
            end
        end
        return e;
    endfunction

    // Font lookup seen on the port k edges after release targets pixel k-1.
    function automatic logic [10:0] exp_font_addr(input int k);
        int          p, x, y;
        logic [15:0] w;
        exp_font_addr = 11'h0;
        if (k >= 1) begin
            p = (k - 1) % FRAME;
            x = p % TH_TOT;
            y = p / TH_TOT;
            if (x < TH_VIS && y < TV_VIS) begin
                w = vram[(y / 16) * 80 + x / 8];
                exp_font_addr = {w[14:8], 4'(y % 16)};
            end
        end
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 4096; i++) vram[i] = 16'($urandom);
    endtask

    task automatic hold_reset();
        @(negedge pixel_clk);
        reset_n = 1'b0;
        repeat (3) @(negedge pixel_clk);
    endtask

    task automatic release_reset();
        @(negedge pixel_clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset_n = 1'b0;
        fill_random();
        repeat (2) @(negedge pixel_clk);
        checks++;
        if (DrawX !== 10'd0 || DrawY !== 10'd0) begin
            errors++; $display("[TB] FAIL reset_pos: got (%0d,%0d) expected (0,0)", DrawX, DrawY);
        end
        checks++;
        if (blank !== 1'b0 || hs !== 1'b1 || vs !== 1'b1 || frame_tick !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_timing: got blank=%b hs=%b vs=%b tick=%b expected 0 1 1 0", blank, hs, vs, frame_tick);
        end
        checks++;
        if (char_w !== 16'h0 || font_data !== 8'h0) begin
            errors++; $display("[TB] FAIL reset_data: got char=%h font=%h expected 0 0", char_w, font_data);
        end
        checks++;
        if (vram_addr !== 12'h0 || font_addr !== 11'h0) begin
            errors++; $display("[TB] FAIL reset_addr: got vram_addr=%0d font_addr=%h expected 0 0", vram_addr, font_addr);
        end
        release_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge pixel_clk);
            e = model(cyc);
            checks++;
            if (DrawX !== 10'(e.x) || DrawY !== 10'(e.y) || blank !== e.blank || hs !== e.hs || vs !== e.vs) begin
                errors++;
                $display("[TB] FAIL release_k%0d: got (%0d,%0d) blank=%b hs=%b vs=%b expected (%0d,%0d) blank=%b hs=%b vs=%b",
                         cyc, DrawX, DrawY, blank, hs, vs, e.x, e.y, e.blank, e.hs, e.vs);
            end
        end
    endtask

    task automatic test_frame();
        exp_t e;
        int   hs_low = 0;
        int   vs_low = 0;
        hold_reset();
        fill_random();
        release_reset();
        for (int i = 0; i < FRAME + 2; i++) begin
            @(negedge pixel_clk);
            e = model(cyc);
            if (cyc >= 2 && cyc < TH_TOT + 2 && hs === 1'b0) hs_low++;
            if (cyc >= 2 && cyc < FRAME + 2 && vs === 1'b0) vs_low++;
            checks++;
            if (DrawX !== 10'(e.x) || DrawY !== 10'(e.y)) begin
                errors++; $display("[TB] FAIL frame_pos k=%0d: got (%0d,%0d) expected (%0d,%0d)", cyc, DrawX, DrawY, e.x, e.y);
            end
            checks++;
            if (blank !== e.blank || hs !== e.hs || vs !== e.vs || frame_tick !== e.tick) begin
                errors++;
                $display("[TB] FAIL frame_timing k=%0d (%0d,%0d): got blank=%b hs=%b vs=%b tick=%b expected %b %b %b %b",
                         cyc, e.x, e.y, blank, hs, vs, frame_tick, e.blank, e.hs, e.vs, e.tick);
            end
            checks++;
            if (char_w !== e.ch || font_data !== e.fd) begin
                errors++;
                $display("[TB] FAIL frame_data k=%0d (%0d,%0d): got char=%h font=%h expected %h %h",
                         cyc, e.x, e.y, char_w, font_data, e.ch, e.fd);
            end
            checks++;
            if (font_addr !== exp_font_addr(cyc)) begin
                errors++; $display("[TB] FAIL frame_font_addr k=%0d: got %h expected %h", cyc, font_addr, exp_font_addr(cyc));
            end
        end
        checks++;
        if (DrawX !== 10'd0 || DrawY !== 10'd0) begin
            errors++; $display("[TB] FAIL frame_wrap: got (%0d,%0d) expected (0,0)", DrawX, DrawY);
        end
        checks++;
        if (hs_low != TH_SYNC) begin
            errors++; $display("[TB] FAIL hs_low_per_line: got %0d expected %0d", hs_low, TH_SYNC);
        end
        checks++;
        if (vs_low != TV_SYNC * TH_TOT) begin
            errors++; $display("[TB] FAIL vs_low_per_frame: got %0d expected %0d", vs_low, TV_SYNC * TH_TOT);
        end
    endtask

    task automatic test_vram_cell();
        exp_t e;
        bit   seen_addr = 1'b0;
        int   p1, x1, y1;
        hold_reset();
        fill_random();
        vram[165] = 16'h8A53;
        release_reset();
        for (int i = 0; i < 48 * TH_TOT + 2; i++) begin
            @(negedge pixel_clk);
            e = model(cyc);
            if (vram_addr === 12'd165) seen_addr = 1'b1;
            if (e.x >= 40 && e.x <= 47 && e.y >= 32 && e.y <= 47 && cyc >= 2) begin
                checks++;
                if (char_w !== 16'h8A53 || font_data !== {4'hA, 4'(e.y % 16)}) begin
                    errors++;
                    $display("[TB] FAIL cell_data (%0d,%0d): got char=%h font=%h expected 8a53 %h",
                             e.x, e.y, char_w, font_data, {4'hA, 4'(e.y % 16)});
                end
                if (e.x == 40 && e.y == 35) begin
                    checks++;
                    if (font_data !== 8'hA3 || char_w !== 16'h8A53) begin
                        errors++; $display("[TB] FAIL cell_40_35: got char=%h font=%h expected 8a53 a3", char_w, font_data);
                    end
                end
            end
            p1 = cyc - 1;
            x1 = p1 % TH_TOT;
            y1 = p1 / TH_TOT;
            if (cyc >= 1 && x1 >= 40 && x1 <= 47 && y1 >= 32 && y1 <= 47) begin
                checks++;
                if (font_addr !== {7'h0A, 4'(y1 % 16)}) begin
                    errors++; $display("[TB] FAIL cell_font_addr (%0d,%0d): got %h expected %h", x1, y1, font_addr, {7'h0A, 4'(y1 % 16)});
                end
            end
        end
        checks++;
        if (!seen_addr) begin
            errors++; $display("[TB] FAIL cell_vram_addr: got no 165 issued expected 165 issued");
        end
    endtask

    task automatic test_blank();
        exp_t e;
        hold_reset();
        for (int i = 0; i < 4096; i++) vram[i] = 16'hFFFF;
        release_reset();
        for (int i = 0; i < FRAME + 2; i++) begin
            @(negedge pixel_clk);
            e = model(cyc);
            if (cyc >= 2 && !e.blank) begin
                checks++;
                if (blank !== 1'b0 || char_w !== 16'h0 || font_data !== 8'h0) begin
                    errors++;
                    $display("[TB] FAIL blank_area (%0d,%0d): got blank=%b char=%h font=%h expected 0 0 0",
                             e.x, e.y, blank, char_w, font_data);
                end
            end else if (cyc >= 2) begin
                checks++;
                if (blank !== 1'b1 || char_w !== 16'hFFFF || font_data !== e.fd) begin
                    errors++;
                    $display("[TB] FAIL blank_visible (%0d,%0d): got blank=%b char=%h font=%h expected 1 ffff %h",
                             e.x, e.y, blank, char_w, font_data, e.fd);
                end
            end
        end
    endtask

    task automatic test_frame_tick();
        int ticks = 0;
        hold_reset();
        fill_random();
        release_reset();
        for (int i = 0; i < 3 * FRAME + 2; i++) begin
            @(negedge pixel_clk);
            if (frame_tick === 1'b1) begin
                ticks++;
                checks++;
                if (DrawX !== 10'd0 || DrawY !== 10'(TV_VIS)) begin
                    errors++; $display("[TB] FAIL tick_pos: got (%0d,%0d) expected (0,%0d)", DrawX, DrawY, TV_VIS);
                end
            end
        end
        checks++;
        if (ticks != 3) begin
            errors++; $display("[TB] FAIL tick_count: got %0d expected 3", ticks);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        bit   found = 1'b0;
        hold_reset();
        fill_random();
        release_reset();
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge pixel_clk);
            if (DrawX === 10'd50 && DrawY === 10'd30) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("[TB] FAIL midreset_reach: got no (50,30) expected (50,30) within bound");
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (DrawX !== 10'd0 || DrawY !== 10'd0 || blank !== 1'b0 || hs !== 1'b1 || vs !== 1'b1 ||
            char_w !== 16'h0 || font_data !== 8'h0 || frame_tick !== 1'b0 || vram_addr !== 12'h0 || font_addr !== 11'h0) begin
            errors++;
            $display("[TB] FAIL midreset_async: got (%0d,%0d) blank=%b hs=%b vs=%b char=%h font=%h tick=%b va=%0d fa=%h expected reset values",
                     DrawX, DrawY, blank, hs, vs, char_w, font_data, frame_tick, vram_addr, font_addr);
        end
        repeat (5) @(negedge pixel_clk);
        release_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge pixel_clk);
            e = model(cyc);
            checks++;
            if (DrawX !== 10'(e.x) || DrawY !== 10'(e.y) || blank !== e.blank || frame_tick !== 1'b0 || char_w !== e.ch) begin
                errors++;
                $display("[TB] FAIL midreset_k%0d: got (%0d,%0d) blank=%b tick=%b char=%h expected (%0d,%0d) blank=%b tick=0 char=%h",
                         cyc, DrawX, DrawY, blank, frame_tick, char_w, e.x, e.y, e.blank, e.ch);
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        $display("[TB] start");
        test_reset();
        test_frame();
        test_vram_cell();
        test_blank();
        test_frame_tick();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
